// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: button indices and the
// single-grant helper used by the press-pulse arbiter.
package calc_pkg;

    localparam int NUM_BTN   = 6;

    localparam int BTN_CALC  = 0;
    localparam int BTN_PLUS  = 1;
    localparam int BTN_MINUS = 2;
    localparam int BTN_H     = 3;
    localparam int BTN_T     = 4;
    localparam int BTN_O     = 5;

    // Isolates the lowest set bit; bit 0 (calc) therefore has top priority.
    function automatic logic [NUM_BTN-1:0] lowest_onehot(input logic [NUM_BTN-1:0] v);
        return v & (~v + NUM_BTN'(1));
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button lane: 2-flop synchronizer, registered polarity normalization,
// and an up-counting debounce filter that owns the stable level.
// `press` is combinational from registered state so the owner can latch the
// event on the same edge that `stable` rises.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int   CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic REL = (BTN_ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // Synchronize the raw pin, then register it as active-high; the sync
    // flops park at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= REL;
            sync2 <= REL;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            level <= sync2 ^ REL;
        end
    end

    assign flip  = (level != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press = flip & ~stable;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (level == stable) begin
            cnt    <= '0;
        end else if (flip) begin
            stable <= ~stable;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Button input conditioner: six debounce lanes feeding a pending-event
// register and a fixed-priority arbiter that emits at most one press pulse
// per clock. Optional feature macro: BTN_AUTO_REPEAT_EN adds auto-repeat on
// the h, t and o buttons; without it each debounced press yields one pulse.
module btn_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_held
);

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] repeat_set;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] grant;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    assign repeat_set[BTN_H-1:0] = '0;

    for (genvar i = BTN_H; i < NUM_BTN; i++) begin : g_rpt
        logic [RW-1:0] cnt;

        // Down-counter armed by the press event; reloads with the period
        // each time it expires while the button stays held.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (press[i]) begin
                cnt <= RW'(REPEAT_DELAY - 1);
            end else if (!stable[i]) begin
                cnt <= '0;
            end else if (cnt == '0) begin
                cnt <= RW'(REPEAT_PERIOD - 1);
            end else begin
                cnt <= cnt - RW'(1);
            end
        end

        assign repeat_set[i] = stable[i] && (cnt == '0);
    end
`else
    assign repeat_set = '0;
`endif

    assign grant = lowest_onehot(pending);

    // Emit the highest-priority pending event; new events landing on the
    // bit being emitted survive because they are OR-ed in after the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            btn_pulse <= '0;
            btn_held  <= '0;
        end else begin
            pending   <= (pending & ~grant) | press | repeat_set;
            btn_pulse <= grant;
            btn_held  <= stable;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
// Each scenario logs btn_pulse/btn_held one step after every rising edge;
// log index k is the value following edge k, edge 0 being the first edge
// that samples the new pin level.
module tb_btn_conditioner;
    import calc_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;

    logic       clk;
    logic       rst;
    logic [5:0] btn_raw;
    logic [5:0] btn_pulse;
    logic [5:0] btn_held;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .BTN_ACTIVE_LOW (1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_held (btn_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [5:0] pulse_log [64];
    logic [5:0] held_log  [64];
    int         log_len;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (log_len < 64) begin
                pulse_log[log_len] = btn_pulse;
                held_log[log_len]  = btn_held;
                log_len++;
            end
        end
    endtask

    function automatic int pulse_cycles();
        int n = 0;
        for (int k = 0; k < log_len; k++)
            if (pulse_log[k] != 6'b0) n++;
        return n;
    endfunction

    function automatic logic [5:0] held_or();
        logic [5:0] acc = '0;
        for (int k = 0; k < log_len; k++)
            acc |= held_log[k];
        return acc;
    endfunction

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] exp_p;

        rst     = 1'b0;
        btn_raw = 6'h3F;
        log_len = 0;
        tick(3);
        check_val("reset_pulse", btn_pulse, 6'b0);
        check_val("reset_held", btn_held, 6'b0);
        rst = 1'b1;
        tick(5);

        // Clean press of plus, held 20 cycles, then release.
        log_len = 0;
        btn_raw = ~6'b000010;
        tick(20);
        check_val("plus_pre", pulse_log[6], 6'b0);
        check_val("plus_pulse", pulse_log[7], 6'b000010);
        check_val("plus_post", pulse_log[8], 6'b0);
        check_val("plus_count", pulse_cycles(), 1);
        check_val("plus_held_lo", held_log[6], 6'b0);
        check_val("plus_held_hi", held_log[7], 6'b000010);
        check_val("plus_held_end", held_log[19], 6'b000010);
        log_len = 0;
        btn_raw = 6'h3F;
        tick(12);
        check_val("plus_rel_held", held_log[6], 6'b000010);
        check_val("plus_rel_drop", held_log[7], 6'b0);
        check_val("plus_rel_nopulse", pulse_cycles(), 0);

        // Bounce on h: low 3, high 1, low 3, high.
        log_len = 0;
        btn_raw = ~6'b001000; tick(3);
        btn_raw = 6'h3F;      tick(1);
        btn_raw = ~6'b001000; tick(3);
        btn_raw = 6'h3F;      tick(13);
        check_val("bounce_nopulse", pulse_cycles(), 0);
        check_val("bounce_held", held_or(), 6'b0);

        // Simultaneous calc, minus, o.
        log_len = 0;
        btn_raw = ~6'b100101;
        tick(14);
        check_val("multi_pre", pulse_log[6], 6'b0);
        check_val("multi_calc", pulse_log[7], 6'b000001);
        check_val("multi_minus", pulse_log[8], 6'b000100);
        check_val("multi_o", pulse_log[9], 6'b100000);
        check_val("multi_after", pulse_log[10], 6'b0);
        check_val("multi_count", pulse_cycles(), 3);
        check_val("multi_held", held_log[13], 6'b100101);
        btn_raw = 6'h3F;
        tick(12);

        // Reset while h is held and debounced.
        log_len = 0;
        btn_raw = ~6'b001000;
        tick(10);
        check_val("rst_held_before", held_log[9], 6'b001000);
        rst = 1'b0;
        #1;
        check_val("rst_async_pulse", btn_pulse, 6'b0);
        check_val("rst_async_held", btn_held, 6'b0);
        tick(2);
        check_val("rst_during_held", btn_held, 6'b0);
        rst = 1'b1;
        log_len = 0;
        tick(15);
        check_val("rst_pre", pulse_log[6], 6'b0);
        check_val("rst_pulse", pulse_log[7], 6'b001000);
        check_val("rst_count", pulse_cycles(), 1);
        btn_raw = 6'h3F;
        tick(12);

        // t held 40 cycles: one pulse, or auto-repeat when enabled.
        log_len = 0;
        btn_raw = ~6'b010000;
        tick(40);
        for (int k = 0; k < 40; k++) begin
            exp_p = (k == 7) ? 6'b010000 : 6'b0;
`ifdef BTN_AUTO_REPEAT_EN
            if (k >= 7 + RD && ((k - 7 - RD) % RP) == 0) exp_p = 6'b010000;
`endif
            check_val($sformatf("t_hold[%0d]", k), pulse_log[k], exp_p);
        end
        log_len = 0;
        btn_raw = 6'h3F;
        tick(15);
`ifndef BTN_AUTO_REPEAT_EN
        check_val("t_rel_nopulse", pulse_cycles(), 0);
`endif
        check_val("t_rel_held", held_log[14], 6'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side conditioning stage for the calculator datapath. Takes the six raw push-button levels (calc, plus, minus, h, t, o) straight from the board pins and turns each into a clean, debounced, single-cycle press pulse. Pulses are serialized so that at most one pulse is asserted per clock. The outputs drive the calculator core's button inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a synchronized input must disagree with the stable state before the stable state flips; legal range ≥ 2.
- `BTN_ACTIVE_LOW`, 1: 1 = raw pins read 0 when pressed; 0 = pins read 1 when pressed.
- `REPEAT_DELAY`, 25000000: cycles from press event to first auto-repeat (used only with the macro).
- `REPEAT_PERIOD`, 5000000: cycles between subsequent auto-repeats (used only with the macro).
- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `btn_raw`  in  6: raw pins. Bit mapping: [0] calc, [1] plus, [2] minus, [3] h, [4] t, [5] o.
- `btn_pulse`  out  6: one-cycle press pulses, same bit mapping; at most one bit high per cycle.
- `btn_held`  out  6: debounced stable level, active-high = pressed.

## Operation
- Per bit: 2-flop synchronizer, then polarity normalization to active-high, then a debounce cell.
- The debounce cell holds `stable` and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If the synced input equals `stable`: counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEBOUNCE_CYCLES, `stable` toggles and the counter clears.
- Press event: `stable` toggles 0→1. Release (1→0) produces no pulse.
- `pending[5:0]`: a press event sets `pending[i]` on the same edge that `stable` toggles.
- Arbiter, each edge:
  - The lowest-index set pending bit k is emitted: `btn_pulse` becomes one-hot k for the next cycle, and `pending[k]` clears.
  - With no pending bits, `btn_pulse` = 0.
  - Priority order: calc > plus > minus > h > t > o.
- Press event on bit i while `pending[i]` is already set: the events merge (no double count). This can occur only with tiny DEBOUNCE_CYCLES or auto-repeat.
- Press event on bit i in the same edge that `pending[i]` is emitted: `pending[i]` stays set, so the second event is not lost.
- `btn_held` = `stable` vector, registered.

## Timing
- Reset values: `btn_pulse` = 0, `btn_held` = 0, `stable` = 0, counters = 0, pending = 0. Synchronizer flops reset to the released level (1 if `BTN_ACTIVE_LOW`, else 0).
- Press latency, uncontended: raw pressed before edge 0 and held → synced at edge 2 → `stable` = 1 and pending set at edge 2+DEBOUNCE_CYCLES → `btn_pulse` high for exactly one cycle after edge 3+DEBOUNCE_CYCLES.
- Contention: with n simultaneous events, the pulses appear on n consecutive cycles in priority order.
- Bounce: any glitch shorter than DEBOUNCE_CYCLES clears the counter and produces no event.
- Reset mid-operation: all state clears immediately. A button still held when `rst` deasserts produces one pulse at the standard latency, counted from the first edge after deassertion.
- `btn_held` lags `stable` by one cycle.

## Configuration
- `BTN_AUTO_REPEAT_EN` defined:
  - Bits 3–5 (h, t, o) each get a repeat counter.
  - While `stable[i]` = 1, the counter sets `pending[i]` REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles.
  - The counter clears when `stable[i]` falls, or on reset.
  - Repeated pulses go through the same arbiter.
- `BTN_AUTO_REPEAT_EN` undefined: no repeat logic is generated. Exactly one pulse per debounced press; `REPEAT_*` parameters are ignored.

## Structure
- Shared package `calc_pkg`:
  - Button index constants: `BTN_CALC`=0, `BTN_PLUS`=1, `BTN_MINUS`=2, `BTN_H`=3, `BTN_T`=4, `BTN_O`=5.
  - `NUM_BTN`=6.
- Sub-module `debounce_cell`: synchronizer, polarity normalization, counter, `stable`, press-event output. Instantiated 6× in a generate loop.
- Pending register, arbiter and optional repeat counters stay in the top level.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1.
- Clean press of plus (`btn_raw[1]` 1→0, held 20 cycles) → `btn_pulse` = 6'b000010 for exactly one cycle, 7 cycles after the first low sample. `btn_held[1]` = 1 until release + 7 cycles. No pulse on release.
- Bounce: `btn_raw[3]` low 3 cycles, high 1, low 3, high → no pulse, `btn_held` stays 0.
- Simultaneous press of calc, minus and o on the same edge → pulses 000001, 000100, 100000 on three consecutive cycles.
- Assert `rst` low while h is held and `stable` = 1, release after 2 cycles, h still held → outputs 0 during reset, then a single pulse on bit 3 at 7 cycles after the first post-reset edge.
- `BTN_AUTO_REPEAT_EN` with REPEAT_DELAY=10, REPEAT_PERIOD=5, t held 40 cycles → first pulse at 7 cycles, repeats at +10, +15, +20, … until release. With the macro undefined → only the first pulse.
